reconstructor_dividendo: RTL and testbench

Sequential signed shift-add unit that runs the division datapath backwards. From a quotient, divisor and remainder it rebuilds the dividend: Num = Coc·Den + Res. It sits beside the divisor in the verification environment. Its Start/Done handshake mirrors the divisor's, so the divisor outputs (Coc, Res, Done) can be fed straight back in for round-trip checks. It is also usable as a standalone multiply-accumulate block.

---
 rtl/reconstructor_pkg.sv | 18 +
 rtl/reconstructor_datapath.sv | 72 +++++++
 rtl/reconstructor_dividendo.sv | 119 +++++++++++
 tb/tb_reconstructor_dividendo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reconstructor_pkg.sv
// Shared types for the dividend reconstructor: FSM state encoding and the
// iteration counter width derived from the operand width.
package reconstructor_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        SIGN = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } estado_t;

    // One extra bit over ceil(log2(t)) so the terminal count t-1 never wraps.
    function automatic int cnt_width(input int t);
        return $clog2(t) + 1;
    endfunction

endpackage

// File: rtl/reconstructor_datapath.sv
// Datapath of the reconstructor: magnitude/sign capture, radix-2 shift-add
// multiplier, conditional negation and the final remainder adder.
module reconstructor_datapath #(
    parameter int tamanyo = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_negate,
    input  logic                 i_add,
    input  logic [tamanyo-1:0]   i_coc,
    input  logic [tamanyo-1:0]   i_den,
    input  logic [tamanyo-1:0]   i_res,
    output logic [2*tamanyo:0]   o_full
);

    localparam int T = tamanyo;
    localparam int W = 2 * tamanyo;

    logic [W-1:0] r_mcand;
    logic [T-1:0] r_mplier;
    logic [W-1:0] r_acc;
    logic [W:0]   r_prod;
    logic         r_sgn;
    logic [T-1:0] r_res;

    logic [T-1:0] w_coc_mag;
    logic [T-1:0] w_den_mag;
    logic [W:0]   w_acc_ext;
    logic [W:0]   w_res_ext;

    // The magnitude of the most negative value is 2^(T-1), which is exactly
    // representable as an unsigned T-bit number, so no saturation is needed.
    assign w_coc_mag = i_coc[T-1] ? (~i_coc + T'(1)) : i_coc;
    assign w_den_mag = i_den[T-1] ? (~i_den + T'(1)) : i_den;
    assign w_acc_ext = {1'b0, r_acc};
    assign w_res_ext = {{(T+1){r_res[T-1]}}, r_res};
    assign o_full    = r_prod + w_res_ext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_sgn    <= 1'b0;
            r_res    <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= {{T{1'b0}}, w_coc_mag};
                r_mplier <= w_den_mag;
                r_acc    <= '0;
                r_sgn    <= i_coc[T-1] ^ i_den[T-1];
                r_res    <= i_res;
            end else if (i_step) begin
                // Multiplicand shifts left while the multiplier shifts right,
                // so bit 0 of r_mplier is always bit i of |Den|.
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end else if (i_negate) begin
                r_prod <= r_sgn ? (-w_acc_ext) : w_acc_ext;
            end else if (i_add) begin
                r_acc <= '0;
            end
        end
    end

endmodule

// File: rtl/reconstructor_dividendo.sv
// Rebuilds a dividend from quotient, divisor and remainder: Num = Coc*Den + Res.
// Holds the control FSM, the iteration counter and the registered outputs.
module reconstructor_dividendo
    import reconstructor_pkg::*;
#(
    parameter int tamanyo = 32
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic [tamanyo-1:0] Coc,
    input  logic [tamanyo-1:0] Den,
    input  logic [tamanyo-1:0] Res,
    output logic [tamanyo-1:0] Num,
    output logic               Ovf,
    output logic               Done,
    output logic               Busy
);

    localparam int T  = tamanyo;
    localparam int CW = cnt_width(tamanyo);

    generate
        if (tamanyo < 4) begin : g_bad_width
            $error("reconstructor_dividendo: tamanyo must be at least 4");
        end
    endgenerate

    estado_t       r_estado;
    logic [CW-1:0] r_cnt;
    logic [T-1:0]  r_num;
    logic          r_ovf;
    logic          r_done;
    logic          r_busy;

    logic          w_load;
    logic          w_step;
    logic          w_negate;
    logic          w_add;
    logic [2*T:0]  w_full;
    logic [T+1:0]  w_hi;
    logic          w_ovf;

    assign w_load   = (r_estado == IDLE) && Start;
    assign w_step   = (r_estado == MULT);
    assign w_negate = (r_estado == SIGN);
    assign w_add    = (r_estado == ADD);

    reconstructor_datapath #(
        .tamanyo (tamanyo)
    ) u_datapath (
        .i_clk    (CLK),
        .i_rst    (RSTa),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_negate (w_negate),
        .i_add    (w_add),
        .i_coc    (Coc),
        .i_den    (Den),
        .i_res    (Res),
        .o_full   (w_full)
    );

    // The result fits only if every bit from the sign bit of Num upwards agrees.
    assign w_hi  = w_full[2*T:T-1];
    assign w_ovf = ~((w_hi == '0) || (&w_hi));

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            r_estado <= IDLE;
            r_cnt    <= '0;
            r_num    <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (Start) begin
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_estado <= MULT;
                    end
                end
                MULT: begin
                    if (r_cnt == CW'(T - 1)) begin
                        r_estado <= SIGN;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SIGN: begin
                    r_estado <= ADD;
                end
                ADD: begin
                    r_num    <= w_full[T-1:0];
                    r_ovf    <= w_ovf;
                    r_done   <= 1'b1;
                    r_estado <= DONE;
                end
                DONE: begin
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                    r_estado <= IDLE;
                end
                default: begin
                    r_estado <= IDLE;
                end
            endcase
        end
    end

    assign Num  = r_num;
    assign Ovf  = r_ovf;
    assign Done = r_done;
    assign Busy = r_busy;

endmodule

// File: tb/tb_reconstructor_dividendo.sv
// Self-checking bench for reconstructor_dividendo at tamanyo=8, using an
// integer-arithmetic reference model and a truncating-divisor round trip.
module tb_reconstructor_dividendo;

  localparam int T = 8;
  localparam int LAT = T + 2;

  logic         CLK;
  logic         RSTa;
  logic         Start;
  logic [T-1:0] Coc;
  logic [T-1:0] Den;
  logic [T-1:0] Res;
  logic [T-1:0] Num;
  logic         Ovf;
  logic         Done;
  logic         Busy;

  int n_vec;
  int n_err;

  reconstructor_dividendo #(
    .tamanyo (T)
  ) dut (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .Start (Start),
    .Coc   (Coc),
    .Den   (Den),
    .Res   (Res),
    .Num   (Num),
    .Ovf   (Ovf),
    .Done  (Done),
    .Busy  (Busy)
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed result in plain integer arithmetic.
  function automatic void model(input logic [T-1:0] c, input logic [T-1:0] d,
                                input logic [T-1:0] r,
                                output logic [T-1:0] n, output logic o);
    int f;
    f = int'($signed(c)) * int'($signed(d)) + int'($signed(r));
    n = f[T-1:0];
    o = (f > 127) || (f < -128);
  endfunction

  // Drives one operation, checks latency, result, Done/Busy timing.
  task automatic run_op(input logic [T-1:0] c, input logic [T-1:0] d,
                        input logic [T-1:0] r, input bit poke,
                        output logic [T-1:0] got_num, output logic got_ovf);
    logic [T-1:0] exp_num;
    logic         exp_ovf;
    int           cycles;
    int           extra_done;
    bit           seen;
    model(c, d, r, exp_num, exp_ovf);
    Coc   = c;
    Den   = d;
    Res   = r;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    Coc   = T'($urandom);
    Den   = T'($urandom);
    Res   = T'($urandom);
    check_val("busy_after_e0", 32'(Busy), 32'd1);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      if (poke && cycles == 3) Start = 1'b1;
      if (poke && cycles == 4) Start = 1'b0;
      @(posedge CLK);
      #1;
      cycles++;
      if (Done) seen = 1'b1;
    end
    Start = 1'b0;
    check_val("done_timeout", 32'(seen), 32'd1);
    check_val("latency", 32'(cycles), 32'(LAT));
    got_num = Num;
    got_ovf = Ovf;
    check_val("num", 32'(Num), 32'(exp_num));
    check_val("ovf", 32'(Ovf), 32'(exp_ovf));
    @(posedge CLK);
    #1;
    check_val("done_pulse_end", 32'(Done), 32'd0);
    check_val("busy_fall", 32'(Busy), 32'd0);
    if (poke) begin
      extra_done = 0;
      repeat (15) begin
        @(posedge CLK);
        #1;
        if (Done) extra_done++;
      end
      check_val("no_queued_start", 32'(extra_done), 32'd0);
    end
  endtask

  logic [T-1:0] r_num_got;
  logic         r_ovf_got;
  int           rst_dones;
  int           corner_n[6];
  int           corner_d[6];

  initial begin
    n_vec = 0;
    n_err = 0;
    RSTa  = 1'b1;
    Start = 1'b0;
    Coc   = '0;
    Den   = '0;
    Res   = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_num", 32'(Num), 32'd0);
    check_val("rst_ovf", 32'(Ovf), 32'd0);
    check_val("rst_done", 32'(Done), 32'd0);
    check_val("rst_busy", 32'(Busy), 32'd0);
    RSTa = 1'b0;
    @(posedge CLK);
    #1;

    // directed scenarios
    run_op(8'd7, 8'd6, 8'd5, 1'b0, r_num_got, r_ovf_got);
    check_val("t1_num", 32'(r_num_got), 32'h2F);
    run_op(8'hF9, 8'd3, 8'hFE, 1'b0, r_num_got, r_ovf_got);
    check_val("t2_num", 32'(r_num_got), 32'hE9);
    run_op(8'h80, 8'hFF, 8'h00, 1'b0, r_num_got, r_ovf_got);
    check_val("t3_ovf", 32'(r_ovf_got), 32'd1);
    run_op(8'h80, 8'h01, 8'h00, 1'b0, r_num_got, r_ovf_got);
    check_val("t3b_ovf", 32'(r_ovf_got), 32'd0);
    run_op(8'h55, 8'h00, 8'h12, 1'b1, r_num_got, r_ovf_got);
    check_val("t4_num", 32'(r_num_got), 32'h12);
    run_op(8'h00, 8'h6B, 8'hA0, 1'b0, r_num_got, r_ovf_got);
    check_val("coc0_num", 32'(r_num_got), 32'hA0);

    // reset in the middle of MULT
    Coc   = 8'd3;
    Den   = 8'd3;
    Res   = 8'd1;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_val("pre_rst_busy", 32'(Busy), 32'd1);
    RSTa = 1'b1;
    #1;
    check_val("mid_rst_num", 32'(Num), 32'd0);
    check_val("mid_rst_ovf", 32'(Ovf), 32'd0);
    check_val("mid_rst_done", 32'(Done), 32'd0);
    check_val("mid_rst_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    RSTa = 1'b0;
    rst_dones = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (Done) rst_dones++;
    end
    check_val("rst_no_done", 32'(rst_dones), 32'd0);
    run_op(8'd9, 8'hFD, 8'd4, 1'b0, r_num_got, r_ovf_got);

    // round trip through a truncating divisor model
    corner_n = '{-128, -128, 127, -1, 1, -128};
    corner_d = '{1, -128, -1, 1, -1, 127};
    for (int i = 0; i < 1000; i++) begin
      int n;
      int d;
      int q;
      int rm;
      if (i < 6) begin
        n = corner_n[i];
        d = corner_d[i];
      end else begin
        n = $urandom_range(255) - 128;
        case ($urandom_range(3))
          0: d = 1;
          1: d = -1;
          default: d = $urandom_range(255) - 128;
        endcase
        if (d == 0) d = 1;
      end
      if (n == -128 && d == -1) d = 1;
      q  = n / d;
      rm = n % d;
      run_op(q[T-1:0], d[T-1:0], rm[T-1:0], 1'b0, r_num_got, r_ovf_got);
      check_val("rt_num", 32'(r_num_got), 32'(n[T-1:0]));
      check_val("rt_ovf", 32'(r_ovf_got), 32'd0);
    end

    // unconstrained multiply-accumulate
    for (int i = 0; i < 200; i++) begin
      run_op(T'($urandom), T'($urandom), T'($urandom), 1'b0, r_num_got, r_ovf_got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
